// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic GRANT_IN0 = 1'b0;
  localparam logic GRANT_IN1 = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_grant.sv
// Combinational two-way grant: round-robin with a bounded burst allowance for the current owner.
module mux_rr_grant
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 2,
  parameter int CNT_W     = clog2(MAX_BURST + 1)
) (
  input  logic [1:0]       valid,
  input  logic             owner,
  input  logic [CNT_W-1:0] cnt,
  output logic             sel
);

  always_comb begin
    sel = owner;
    case (valid)
      2'b01:   sel = GRANT_IN0;
      2'b10:   sel = GRANT_IN1;
      // Contention: owner keeps the path until its burst allowance is used up.
      2'b11:   sel = (cnt < CNT_W'(MAX_BURST)) ? owner : ~owner;
      default: sel = owner;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Shares one 2:1 select path between two valid/ready producers with a registered single-entry output.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CNT_W = clog2(MAX_BURST + 1);

  state_t           state, state_next;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_BURST)) return CNT_W'(MAX_BURST);
    return c + CNT_W'(1);
  endfunction

  mux_rr_grant #(
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) u_grant (
    .valid({in1_valid, in0_valid}),
    .owner(owner),
    .cnt  (cnt),
    .sel  (sel)
  );

  assign vld_p1    = (state == ST_FULL);
  assign space     = !vld_p1 | out_ready;
  assign in0_ready = space & (sel == GRANT_IN0) & rst_n;
  assign in1_ready = space & (sel == GRANT_IN1) & rst_n;
  assign accept    = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign sel_data  = sel ? in1_data : in0_data;
  assign busy      = vld_p1 | in0_valid | in1_valid;

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Stage p1: selected word registered on accept, held under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n)      data_p1 <= '0;
    else if (accept) data_p1 <= sel_data;
  end

  // Bookkeeping only moves on an accept so idle or blocked cycles never shift fairness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner <= GRANT_IN1;
      cnt   <= CNT_W'(MAX_BURST);
    end else if (accept) begin
      if (sel == owner) begin
        cnt <= sat_inc(cnt);
      end else begin
        owner <= sel;
        cnt   <= CNT_W'(1);
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule
